// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences a synchronous-read imem and
// presents tagged words over valid/ready with a one-entry skid buffer. Optional perf counters via IFETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY,
        STREAM,
        HELD
    } state_e;

    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    state_e      state;
    logic        issue;

    always_comb begin
        state = EMPTY;
        if (skid_v_q) begin
            state = HELD;
        end else if (infl_v_q) begin
            state = STREAM;
        end

        if_valid  = (infl_v_q | skid_v_q) & ~redirect_valid;
        if_instr  = (state == HELD) ? skid_instr_q : imem_instr;
        if_pc     = (state == HELD) ? skid_pc_q : infl_pc_q;
        imem_addr = (redirect_valid && !rst) ? redirect_pc : pc_q;
        issue     = !rst && (redirect_valid || !(if_valid && !if_ready));

        pc_d         = pc_q;
        infl_v_d     = 1'b0;
        infl_pc_d    = infl_pc_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (issue) begin
            infl_v_d  = 1'b1;
            infl_pc_d = imem_addr;
            pc_d      = imem_addr + 32'(PC_STEP);
        end

        // A redirect squashes whatever is held; otherwise the skid fills or drains.
        if (redirect_valid) begin
            skid_v_d = 1'b0;
        end else begin
            case (state)
                STREAM: begin
                    if (!if_ready) begin
                        skid_v_d     = 1'b1;
                        skid_instr_d = imem_instr;
                        skid_pc_d    = infl_pc_q;
                    end
                end
                HELD: begin
                    if (if_ready) begin
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            infl_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            infl_v_q <= infl_v_d;
            skid_v_q <= skid_v_d;
        end
        infl_pc_q    <= infl_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, (if_valid && if_ready)};
        stall_cnt_d = stall_cnt_q + {31'd0, (if_valid && !if_ready)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: stream, back-pressure, redirects, reset and PC wrap,
// plus counter checks when IFETCH_PERF_CNT_EN is defined.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int compare_count = 0;
    int fail_count    = 0;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: preloaded words, everything else tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0011_0533;
            32'h0000_0004: return 32'h4032_05B3;
            32'h0000_0008: return 32'h0011_4633;
            32'h0000_0010: return 32'h0011_7733;
            32'h0000_0020: return 32'h0011_2933;
            32'h0000_0024: return 32'h0032_39B3;
            default:       return {16'hA5A5, addr[15:0]};
        endcase
    endfunction

    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst            = r;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectCycle(input string tag, input logic v, input logic [31:0] addr,
                               input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        checkOutput({tag, ".addr"}, imem_addr, addr);
        if (v) begin
            checkOutput({tag, ".pc"}, if_pc, pc);
            checkOutput({tag, ".instr"}, if_instr, instr);
        end
    endtask

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        applyStimulus(1, 1, 0, 0);             expectCycle("reset0", 0, 32'h0, 0, 0);
        applyStimulus(1, 1, 0, 0);             expectCycle("reset1", 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("first_issue", 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("seq0", 1, 32'h4, 32'h0, 32'h0011_0533);
        // pc 4 is stalled for three cycles, then accepted
        applyStimulus(0, 0, 0, 0);             expectCycle("stall0", 1, 32'h8, 32'h4, 32'h4032_05B3);
        applyStimulus(0, 0, 0, 0);             expectCycle("stall1", 1, 32'h8, 32'h4, 32'h4032_05B3);
        applyStimulus(0, 0, 0, 0);             expectCycle("stall2", 1, 32'h8, 32'h4, 32'h4032_05B3);
        applyStimulus(0, 1, 0, 0);             expectCycle("release", 1, 32'h8, 32'h4, 32'h4032_05B3);
        applyStimulus(0, 1, 0, 0);             expectCycle("seq8", 1, 32'hC, 32'h8, 32'h0011_4633);
        applyStimulus(0, 1, 1, 32'h20);        expectCycle("redir", 0, 32'h20, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("redir_t0", 1, 32'h24, 32'h20, 32'h0011_2933);
        applyStimulus(0, 1, 0, 0);             expectCycle("redir_t1", 1, 32'h28, 32'h24, 32'h0032_39B3);
        applyStimulus(0, 0, 0, 0);             expectCycle("hold28a", 1, 32'h2C, 32'h28, 32'hA5A5_0028);
        applyStimulus(0, 0, 0, 0);             expectCycle("hold28b", 1, 32'h2C, 32'h28, 32'hA5A5_0028);
        // reset while HELD discards the held word
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("post_rst", 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("restart0", 1, 32'h4, 32'h0, 32'h0011_0533);
        applyStimulus(0, 0, 0, 0);             expectCycle("skid4", 1, 32'h8, 32'h4, 32'h4032_05B3);
        applyStimulus(0, 0, 1, 32'h10);        expectCycle("redir_held", 0, 32'h10, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("redir_held_t", 1, 32'h14, 32'h10, 32'h0011_7733);
        applyStimulus(0, 0, 0, 0);             expectCycle("stall14a", 1, 32'h18, 32'h14, 32'hA5A5_0014);
        applyStimulus(0, 0, 0, 0);             expectCycle("stall14b", 1, 32'h18, 32'h14, 32'hA5A5_0014);
        applyStimulus(0, 1, 0, 0);             expectCycle("accept14", 1, 32'h18, 32'h14, 32'hA5A5_0014);
        applyStimulus(0, 1, 0, 0);             expectCycle("seq18", 1, 32'h1C, 32'h18, 32'hA5A5_0018);
        applyStimulus(0, 1, 0, 0);             expectCycle("seq1c", 1, 32'h20, 32'h1C, 32'hA5A5_001C);
        applyStimulus(0, 0, 0, 0);             expectCycle("seq20", 1, 32'h24, 32'h20, 32'h0011_2933);
`ifdef IFETCH_PERF_CNT_EN
        // since the mid-run reset: accepted at 0,0x10,0x14,0x18,0x1C; stalled at 4 and twice at 0x14
        checkOutput("perf_fetch", perf_fetch_cnt, 32'd5);
        checkOutput("perf_stall", perf_stall_cnt, 32'd3);
`endif
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("post_rst2", 0, 32'h0, 0, 0);
`ifdef IFETCH_PERF_CNT_EN
        checkOutput("perf_fetch_clr", perf_fetch_cnt, 32'd0);
        checkOutput("perf_stall_clr", perf_stall_cnt, 32'd0);
`endif
        // PC increment wraps modulo 2^32
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC); expectCycle("redir_wrap", 0, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(0, 1, 0, 0);             expectCycle("wrap_top", 1, 32'h0, 32'hFFFF_FFFC, 32'hA5A5_FFFC);
        applyStimulus(0, 1, 0, 0);             expectCycle("wrap_zero", 1, 32'h4, 32'h0, 32'h0011_0533);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
